// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mult/div sequencer owning HI/LO with pipeline stall
// Magnitudes are iterated; signs are reapplied in FIX.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_mfhi_req,
  input  logic             i_mflo_req,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_rs_neg;
  logic             r_rt_neg;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rs_orig;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic             w_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_signed = ~i_op[0];
  assign w_rs_neg = w_signed & i_rs_val[WIDTH-1];
  assign w_rt_neg = w_signed & i_rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -i_rs_val : i_rs_val;
  assign w_rt_mag = w_rt_neg ? -i_rt_val : i_rt_val;

  // Multiply: upper half accumulates, multiplier bits shift out of the low end.
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  // Divide: upper half is the partial remainder, quotient bits shift into the low end.
  assign w_shl  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_shl - {1'b0, r_b};

  always_comb begin
    w_acc_step = {w_add, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_diff[WIDTH])
        w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
      else
        w_acc_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  assign w_prod = (r_rs_neg ^ r_rt_neg) ? -r_acc : r_acc;
  assign w_quo  = (r_rs_neg ^ r_rt_neg) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_rs_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_rs_neg   <= 1'b0;
      r_rt_neg   <= 1'b0;
      r_div_zero <= 1'b0;
      r_b        <= '0;
      r_rs_orig  <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_is_div   <= i_op[1];
            r_rs_neg   <= w_rs_neg;
            r_rt_neg   <= w_rt_neg;
            r_div_zero <= (i_rt_val == '0);
            r_rs_orig  <= i_rs_val;
            r_b        <= i_op[1] ? w_rt_mag : w_rs_mag;
            r_acc      <= {{WIDTH{1'b0}}, (i_op[1] ? w_rs_mag : w_rt_mag)};
          end else begin
            if (i_mthi) r_hi <= i_wr_data;
            if (i_mtlo) r_lo <= i_wr_data;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_div_zero) begin
            r_hi <= r_rs_orig;
            r_lo <= '1;
            r_dz <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dz;
  assign o_stall       = r_busy & (i_start | i_mfhi_req | i_mflo_req | i_mthi | i_mtlo);

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the pipelined MIPS core. It accepts `mult`/`multu`/`div`/`divu` from the EX stage and runs a 32-iteration shift-add multiply or restoring divide. It owns the architectural HI/LO registers and raises the pipeline stall whenever an instruction needs HI/LO, or a new mult/div arrives, while an operation is in flight.

## Interface
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX-stage mult/div valid; sampled only in IDLE.
- op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- mfhi_req, mflo_req  in  1  EX-stage read of HI/LO.
- mthi, mtlo  in  1  EX-stage write of HI/LO from wr_data.
- wr_data  in  WIDTH  data for mthi/mtlo.
- hi, lo  out  WIDTH  architectural HI/LO (registered).
- busy  out  1  high in RUN and FIX.
- stall  out  1  combinational pipeline freeze.
- done  out  1  one-cycle pulse after HI/LO are updated by an operation.
- div_by_zero  out  1  one-cycle pulse, coincident with done, for div/divu with rt_val==0.

## Operation
- States:
  - IDLE→RUN on start, which latches op, the operand magnitudes and the sign bits; the iteration counter is cleared.
  - RUN runs for WIDTH edges, then goes to FIX.
  - FIX goes to IDLE after one edge.
- Signed ops (mult, div) convert the operands to magnitudes at start. Unsigned ops use them raw.
- Multiply: 2·WIDTH accumulator, shift-add, one multiplier bit per RUN cycle.
- Divide: restoring divide, one quotient bit per RUN cycle.
- FIX stage:
  - Multiply writes {hi,lo} = product, negated if the operand signs differ.
  - Divide writes lo = quotient, negated if the signs differ, and hi = remainder, carrying the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (natural wrap).
- Divide by zero: full latency still applies. FIX forces hi=rs_val (original value) and lo=0xFFFFFFFF, and div_by_zero pulses.
- Stall: stall = busy & (start | mfhi_req | mflo_req | mthi | mtlo).
  - start while busy is ignored. The pipeline holds the instruction until stall drops.
- mthi/mtlo while IDLE write hi/lo at the edge.
  - start together with mthi/mtlo in IDLE: start wins and the move is dropped.
  - mthi and mtlo together: both are written.
- hi and lo are read directly, with no bypass. In the done cycle they already hold the new result.
- Reset in any state: state=IDLE, counter=0, hi=lo=0, busy=0, done=0, div_by_zero=0. Any in-flight op is discarded.

## Timing
- Edge E0 samples start; busy=1 from E0 through edge E0+WIDTH+1.
- The FIX edge is E0+WIDTH+1 (E0+33 at default). hi/lo update there, done=1 for the following cycle, busy=0 in that cycle, and stall is released the same cycle.
- Total latency from start edge to valid HI/LO: WIDTH+1 edges. Back-to-back issue: the next start is accepted in the done cycle.
- stall has no register delay; it must settle within the EX-stage cycle.
- Counter width is ceil(log2(WIDTH))+1. It never wraps, because FIX is entered at count==WIDTH-1.

## Test plan
- mult rs=7, rt=-3 (0xFFFFFFFD): at E0+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- multu rs=0xFFFFFFFF, rt=2: hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
- div rs=-7, rt=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). div rs=0x80000000, rt=-1: lo=0x80000000, hi=0.
- divu rs=100, rt=0: hi=100, lo=0xFFFFFFFF, div_by_zero and done both pulse at E0+33.
- mult in flight, mfhi_req held from E0+5: stall=1 every cycle through E0+33, 0 in the done cycle. A second start during busy leaves the result of the first op intact.
- rst at E0+10 of a div: next cycle busy=0, hi=lo=0, no done pulse. mthi wr_data=0x1234 then reads hi=0x1234.
